// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: converts latched samples into deterministic rate-coded spike trains via per-channel phase accumulators.
module spike_rate_encoder #(
  parameter int NUM_INPUTS  = 1,
  parameter int VALUE_WIDTH = 8,
  parameter int WINDOW      = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_INPUTS*VALUE_WIDTH-1:0] in_value,
  input  logic                              step_en,
  output logic [NUM_INPUTS-1:0]             spike_out,
  output logic                              busy,
  output logic                              window_done
);
  localparam int VW = VALUE_WIDTH;
  localparam int CW = $clog2(WINDOW + 1);
  typedef enum logic {IDLE, ENCODE} state_t;
  state_t state, state_nx;
  logic [NUM_INPUTS*VW-1:0] val_q, acc_q, acc_nx;
  logic [NUM_INPUTS-1:0] carry;
  logic [CW-1:0] cnt;
  logic accept, step, last;
  assign in_ready = state == IDLE;
  assign busy     = state == ENCODE;
  always_comb begin
    accept   = in_valid && state == IDLE;
    step     = step_en && state == ENCODE;
    last     = step && cnt == CW'(WINDOW - 1);
    state_nx = accept ? ENCODE : last ? IDLE : state;
  end
  // the carry out of each accumulator is the only spike source; the sum wraps
  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
    assign {carry[g], acc_nx[g*VW +: VW]} = {1'b0, acc_q[g*VW +: VW]} + {1'b0, val_q[g*VW +: VW]};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      spike_out   <= '0;
      window_done <= 1'b0;
      val_q       <= '0;
      acc_q       <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_nx;
      spike_out   <= step ? carry : '0;
      window_done <= last;
      if (accept) begin
        val_q <= in_value;
        acc_q <= '0;
        cnt   <= '0;
      end else if (step) begin
        acc_q <= acc_nx;
        cnt   <= cnt + 1'b1;
      end
    end
  end
endmodule
